// File: rtl/instr_mem_loadable_pkg.sv
// instr_mem_loadable_pkg: shared state encoding and core-wide defaults for the instruction memory.
package instr_mem_loadable_pkg;
  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;
  localparam int DATA_W_DEF = 16;
  localparam int PC_W_DEF = 16;
  localparam logic [15:0] NOP = 16'h0000;
endpackage

// File: rtl/instr_mem_loadable_ram.sv
// instr_mem_loadable_ram: DEPTH x DATA_W array, one muxed write port (clear/loader), one registered read port.
module instr_mem_loadable_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 16,
  parameter logic [DATA_W-1:0] FILL = '0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [AW-1:0]     clr_ptr,
  input  logic              ld_we,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              re,
  input  logic              rfill,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;
  always_comb begin
    we = clear || ld_we;
    waddr = clear ? clr_ptr : ld_addr;
    wdata = clear ? FILL : ld_data;
  end
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // A faulting fetch still loads the read register so that instr holds FILL afterwards.
  always_ff @(posedge clk or posedge reset)
    if (reset) rdata <= FILL;
    else if (re) rdata <= rfill ? FILL : mem[raddr];
endmodule

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: loadable instruction memory with post-reset clear, registered fetch port and bootloader port.
module instr_mem_loadable
  import instr_mem_loadable_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W = PC_W_DEF,
  parameter int DEPTH = 16,
  parameter logic [DATA_W-1:0] FILL = DATA_W'(NOP),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   pc,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fault,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [AW:0]       load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_err,
  output logic              busy
);
  state_t        state;
  logic [AW-1:0] ptr;
  logic          accept, bad, beat, ld_we;
  always_comb begin
    fetch_ready = state == RUN && !load_en;
    load_ready = state == LOAD;
    busy = state != RUN;
    accept = fetch_req && fetch_ready;
    // Every pc bit above the word index takes part, so large pcs never alias.
    bad = pc[0] || |pc[PC_W-1:AW+1];
    beat = load_ready && load_en && load_valid;
    ld_we = beat && !load_addr[AW];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CLEAR;
      ptr <= '0;
      instr_valid <= 1'b0;
      fault <= 1'b0;
      load_err <= 1'b0;
    end else begin
      instr_valid <= accept;
      fault <= accept && bad;
      if (state == CLEAR) begin
        ptr <= ptr + 1'b1;
        if (ptr == AW'(DEPTH - 1)) state <= RUN;
      end
      if (state == RUN && load_en) begin
        state <= LOAD;
        load_err <= 1'b0;
      end
      if (state == LOAD && !load_en) state <= RUN;
      if (beat && load_addr[AW]) load_err <= 1'b1;
    end
  instr_mem_loadable_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FILL(FILL)) u_ram (
    .clk(clk),
    .reset(reset),
    .clear(state == CLEAR),
    .clr_ptr(ptr),
    .ld_we(ld_we),
    .ld_addr(load_addr[AW-1:0]),
    .ld_data(load_data),
    .re(accept),
    .rfill(bad),
    .raddr(pc[AW:1]),
    .rdata(instr)
  );
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: randomized scoreboard bench against a word-array reference model.
module tb_instr_mem_loadable;
  localparam int DEPTH = 16;
  typedef struct {
    logic [15:0] instr;
    logic        fault;
    int          due;
  } exp_t;
  logic        clk = 0, reset = 1, fetch_req = 0, load_en = 0, load_valid = 0;
  logic [15:0] pc = 0, load_data = 0;
  logic [4:0]  load_addr = 0;
  logic        fetch_ready, instr_valid, fault, load_ready, load_err, busy;
  logic [15:0] instr;
  logic [15:0] mem_m [DEPTH];
  logic        err_m;
  exp_t        q [$];
  int          cyc = 0, checks = 0, errors = 0;

  instr_mem_loadable dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc), .fetch_ready(fetch_ready),
    .instr(instr), .instr_valid(instr_valid), .fault(fault), .load_en(load_en),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (instr_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cyc=%0d instr=%h", cyc, instr);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (instr !== e.instr || fault !== e.fault || cyc != e.due) begin
          errors++;
          $display("FAIL fetch got instr=%h fault=%b cyc=%0d want instr=%h fault=%b cyc=%0d",
                   instr, fault, cyc, e.instr, e.fault, e.due);
        end
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_valid cyc=%0d want instr=%h", cyc, q[0].instr);
      void'(q.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fetch_req = 0;
    load_en = 0;
    load_valid = 0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    int n;
    reset = 1;
    fetch_req = 0;
    load_en = 0;
    load_valid = 0;
    #1;
    q.delete();
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_fault", fault, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_busy", busy, 1);
    foreach (mem_m[i]) mem_m[i] = 16'h0000;
    err_m = 0;
    step();
    reset = 0;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("clear_cycles", n, 16);
    chk("ready_after_clear", fetch_ready, 1);
  endtask

  task automatic fetch(input logic [15:0] p);
    exp_t e;
    logic b;
    b = p[0] || (p >> 1) >= DEPTH;
    e.instr = b ? 16'h0000 : mem_m[p[4:1]];
    e.fault = b;
    e.due = cyc + 1;
    fetch_req = 1;
    load_en = 0;
    pc = p;
    q.push_back(e);
    step();
  endtask

  task automatic begin_load();
    fetch_req = 0;
    load_en = 1;
    load_valid = 0;
    err_m = 0;
    step();
    chk("load_ready", load_ready, 1);
    chk("load_err_cleared", load_err, 0);
  endtask

  task automatic beat(input logic [4:0] a, input logic [15:0] d);
    load_valid = 1;
    load_addr = a;
    load_data = d;
    if (a < DEPTH) mem_m[a[3:0]] = d;
    else err_m = 1;
    step();
  endtask

  task automatic end_load(input logic lv);
    load_en = 0;
    load_valid = lv;
    load_addr = 5'd5;
    load_data = 16'(~$urandom());
    step();
    load_valid = 0;
    chk("load_err_run", load_err, err_m);
    chk("back_in_run", busy, 0);
  endtask

  initial begin
    do_reset();
    fetch(16'h0006);
    idle(2);
    begin_load();
    beat(5'd0, 16'h8180);
    beat(5'd1, 16'h2CB2);
    beat(5'd2, 16'hDC67);
    end_load(0);
    fetch(16'h0000);
    fetch(16'h0002);
    fetch(16'h0004);
    idle(2);
    fetch(16'h0003);
    fetch(16'h0020);
    fetch(16'h0002);
    fetch(16'hFFFE);
    idle(2);
    begin_load();
    beat(5'd16, 16'h1234);
    chk("load_err_set", load_err, 1);
    end_load(1);
    fetch(16'h000A);
    idle(1);
    begin_load();
    end_load(0);
    fetch_req = 1;
    pc = 16'h0000;
    load_en = 1;
    #1;
    chk("ready_blocked", fetch_ready, 0);
    step();
    err_m = 0;
    chk("no_valid_on_block", instr_valid, 0);
    chk("in_load", load_ready, 1);
    fetch_req = 0;
    end_load(0);
    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        begin_load();
        for (int b = $urandom_range(1, 4); b > 0; b--) beat(5'($urandom_range(0, 20)), 16'($urandom()));
        end_load(1'($urandom_range(0, 1)));
      end else if (r == 2) idle(1);
      else fetch(r == 3 ? 16'($urandom()) : 16'($urandom_range(0, 47)));
    end
    idle(2);
    begin_load();
    beat(5'd3, 16'hBEEF);
    beat(5'd4, 16'hCAFE);
    do_reset();
    fetch(16'h0000);
    fetch(16'h0006);
    fetch(16'h0008);
    chk("inflight_valid", instr_valid, 1);
    do_reset();
    idle(3);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
